// File: rtl/reg_wb_pkg.sv
// ============================================================================
// Module  : reg_wb_pkg
// Brief   : Shared types and defaults for the register write-back controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package reg_wb_pkg;

    localparam int PW_DEF = 4;
    localparam int DW_DEF = 8;

    typedef logic [PW_DEF-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_LD   = 2'd1,
        WB_HOLD = 2'd2,
        WB_ALU  = 2'd3
    } wb_src_e;

endpackage

`default_nettype wire

// File: rtl/reg_wb_ctrl_ld_dest_fifo.sv
// ============================================================================
// Module  : ld_dest_fifo
// Brief   : In-order FIFO of outstanding load destination register addresses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ld_dest_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] head
);

    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTRW = IW + 1;

    logic [AW-1:0]   mem [DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;

    // Index wraps at DEPTH-1 and the extra MSB toggles, so non power-of-two depths work too.
    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        if (p[IW-1:0] == IW'(DEPTH - 1))
            return {~p[IW], {IW{1'b0}}};
        else
            return p + PTRW'(1);
    endfunction

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);
    assign head  = mem[rd_ptr[IW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop && !empty)
                rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[IW-1:0]] <= push_addr;
    end

endmodule

`default_nettype wire

// File: rtl/reg_wb_ctrl.sv
// ============================================================================
// Module  : reg_wb_ctrl
// Brief   : Register-file write-back arbiter merging ALU results and load returns.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_wb_ctrl
    import reg_wb_pkg::*;
#(
    parameter int pw    = PW_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_vld,
    input  logic [pw-1:0] alu_addr,
    input  logic [DW-1:0] alu_dat,
    output logic          alu_rdy,
    input  logic          ld_issue,
    input  logic [pw-1:0] ld_issue_addr,
    output logic          ld_issue_rdy,
    input  logic          ld_rsp_vld,
    input  logic [DW-1:0] ld_rsp_dat,
    input  logic [pw-1:0] rd_addrA,
    input  logic [pw-1:0] rd_addrB,
    output logic          stallA,
    output logic          stallB,
    output logic          bypA_vld,
    output logic [DW-1:0] bypA_dat,
    output logic          bypB_vld,
    output logic [DW-1:0] bypB_dat,
    output logic          wr_en,
    output logic [pw-1:0] wr_addr,
    output logic [DW-1:0] wr_dat,
    output logic          err
);

    localparam int NREG = 2 ** pw;

    logic            fifo_full;
    logic            fifo_empty;
    logic [pw-1:0]   fifo_head;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            hold_vld;
    logic [pw-1:0]   hold_addr;
    logic [DW-1:0]   hold_dat;

    logic            l_cand;
    logic            alu_acc;
    logic            issue_acc;
    wb_src_e         src;

    assign l_cand       = ld_rsp_vld && !fifo_empty;
    assign alu_rdy      = !hold_vld || !l_cand;
    assign alu_acc      = alu_vld && alu_rdy;
    assign ld_issue_rdy = !fifo_full && !busy[ld_issue_addr];
    assign issue_acc    = ld_issue && ld_issue_rdy;

    always_comb begin
        src = WB_NONE;
        if (l_cand)
            src = WB_LD;
        else if (hold_vld)
            src = WB_HOLD;
        else if (alu_acc)
            src = WB_ALU;
    end

    // Load clear and issue set never target the same register: busy blocks that issue.
    always_comb begin
        busy_nxt = busy;
        if (src == WB_LD)
            busy_nxt[fifo_head] = 1'b0;
        if (issue_acc)
            busy_nxt[ld_issue_addr] = 1'b1;
    end

    ld_dest_fifo #(
        .DEPTH (DEPTH),
        .AW    (pw)
    ) u_ld_dest_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (issue_acc),
        .push_addr (ld_issue_addr),
        .pop       (l_cand),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_dat    <= '0;
            busy      <= '0;
            hold_vld  <= 1'b0;
            hold_addr <= '0;
            hold_dat  <= '0;
            err       <= 1'b0;
        end else begin
            wr_en <= (src != WB_NONE);
            case (src)
                WB_LD: begin
                    wr_addr <= fifo_head;
                    wr_dat  <= ld_rsp_dat;
                end
                WB_HOLD: begin
                    wr_addr <= hold_addr;
                    wr_dat  <= hold_dat;
                end
                WB_ALU: begin
                    wr_addr <= alu_addr;
                    wr_dat  <= alu_dat;
                end
                default: ;
            endcase

            // A hold slot freed this cycle can be refilled by the ALU on the same edge.
            if (alu_acc && src != WB_ALU) begin
                hold_vld  <= 1'b1;
                hold_addr <= alu_addr;
                hold_dat  <= alu_dat;
            end else if (src == WB_HOLD) begin
                hold_vld <= 1'b0;
            end

            busy <= busy_nxt;

            if ((ld_rsp_vld && fifo_empty) || (alu_acc && busy[alu_addr]))
                err <= 1'b1;
        end
    end

    assign stallA   = busy[rd_addrA] || (hold_vld && hold_addr == rd_addrA);
    assign stallB   = busy[rd_addrB] || (hold_vld && hold_addr == rd_addrB);
    assign bypA_vld = wr_en && (wr_addr == rd_addrA);
    assign bypB_vld = wr_en && (wr_addr == rd_addrB);
    assign bypA_dat = wr_dat;
    assign bypB_dat = wr_dat;

endmodule

`default_nettype wire

// File: tb/tb_reg_wb_ctrl.sv
// ============================================================================
// Module  : tb_reg_wb_ctrl
// Brief   : Directed self-checking bench for reg_wb_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_wb_ctrl;

    logic       clk;
    logic       reset;
    logic       alu_vld;
    logic [3:0] alu_addr;
    logic [7:0] alu_dat;
    logic       alu_rdy;
    logic       ld_issue;
    logic [3:0] ld_issue_addr;
    logic       ld_issue_rdy;
    logic       ld_rsp_vld;
    logic [7:0] ld_rsp_dat;
    logic [3:0] rd_addrA;
    logic [3:0] rd_addrB;
    logic       stallA;
    logic       stallB;
    logic       bypA_vld;
    logic [7:0] bypA_dat;
    logic       bypB_vld;
    logic [7:0] bypB_dat;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_dat;
    logic       err;

    int errors = 0;
    int checks = 0;

    reg_wb_ctrl #(.pw(4), .DW(8), .DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_vld       (alu_vld),
        .alu_addr      (alu_addr),
        .alu_dat       (alu_dat),
        .alu_rdy       (alu_rdy),
        .ld_issue      (ld_issue),
        .ld_issue_addr (ld_issue_addr),
        .ld_issue_rdy  (ld_issue_rdy),
        .ld_rsp_vld    (ld_rsp_vld),
        .ld_rsp_dat    (ld_rsp_dat),
        .rd_addrA      (rd_addrA),
        .rd_addrB      (rd_addrB),
        .stallA        (stallA),
        .stallB        (stallB),
        .bypA_vld      (bypA_vld),
        .bypA_dat      (bypA_dat),
        .bypB_vld      (bypB_vld),
        .bypB_dat      (bypB_dat),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_dat        (wr_dat),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [3:0] a, input logic [7:0] d);
        chk({tag, ".wr_en"}, 32'(wr_en), 32'(en));
        chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(a));
        chk({tag, ".wr_dat"}, 32'(wr_dat), 32'(d));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b0; alu_vld = 1'b0; alu_addr = '0; alu_dat = '0;
        ld_issue = 1'b0; ld_issue_addr = '0; ld_rsp_vld = 1'b0; ld_rsp_dat = '0;
        rd_addrA = '0; rd_addrB = '0;
        #2;
        do_reset();

        // Reset state
        chk_wr("rst", 1'b0, 4'h0, 8'h00);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.alu_rdy", 32'(alu_rdy), 32'd1);
        chk("rst.ld_issue_rdy", 32'(ld_issue_rdy), 32'd1);
        chk("rst.stallA", 32'(stallA), 32'd0);

        // 1: ALU only
        alu_vld = 1'b1; alu_addr = 4'd3; alu_dat = 8'h5A; rd_addrA = 4'd3;
        step();
        alu_vld = 1'b0;
        #1;
        chk_wr("t1", 1'b1, 4'd3, 8'h5A);
        chk("t1.bypA_vld", 32'(bypA_vld), 32'd1);
        chk("t1.bypA_dat", 32'(bypA_dat), 32'h5A);
        chk("t1.stallA", 32'(stallA), 32'd0);
        step();
        chk_wr("t1.idle", 1'b0, 4'd3, 8'h5A);
        chk("t1.bypA_idle", 32'(bypA_vld), 32'd0);

        // 2: load return collides with ALU result
        ld_issue = 1'b1; ld_issue_addr = 4'd2;
        #1;
        chk("t2.issue_rdy", 32'(ld_issue_rdy), 32'd1);
        step();
        ld_issue = 1'b0; rd_addrB = 4'd2;
        #1;
        chk("t2.stallB_busy", 32'(stallB), 32'd1);
        ld_rsp_vld = 1'b1; ld_rsp_dat = 8'h11;
        alu_vld = 1'b1; alu_addr = 4'd4; alu_dat = 8'h22; rd_addrA = 4'd4;
        #1;
        chk("t2.alu_rdy", 32'(alu_rdy), 32'd1);
        step();
        ld_rsp_vld = 1'b0; alu_vld = 1'b0;
        #1;
        chk_wr("t2.ld", 1'b1, 4'd2, 8'h11);
        chk("t2.stallA_hold", 32'(stallA), 32'd1);
        chk("t2.stallB_clr", 32'(stallB), 32'd0);
        chk("t2.bypB_vld", 32'(bypB_vld), 32'd1);
        step();
        chk_wr("t2.alu", 1'b1, 4'd4, 8'h22);
        chk("t2.stallA_done", 32'(stallA), 32'd0);
        chk("t2.bypA_vld", 32'(bypA_vld), 32'd1);
        step();

        // 3: back-pressure with the hold register occupied
        ld_issue = 1'b1; ld_issue_addr = 4'd6;
        step();
        ld_issue_addr = 4'd7;
        step();
        ld_issue = 1'b0;
        ld_rsp_vld = 1'b1; ld_rsp_dat = 8'h33;
        alu_vld = 1'b1; alu_addr = 4'd8; alu_dat = 8'h44;
        #1;
        chk("t3.rdy_empty_hold", 32'(alu_rdy), 32'd1);
        step();
        ld_rsp_dat = 8'h55; alu_addr = 4'd9; alu_dat = 8'h66;
        #1;
        chk_wr("t3.w1", 1'b1, 4'd6, 8'h33);
        chk("t3.rdy_blocked", 32'(alu_rdy), 32'd0);
        step();
        ld_rsp_vld = 1'b0;
        #1;
        chk_wr("t3.w2", 1'b1, 4'd7, 8'h55);
        chk("t3.rdy_hold_drain", 32'(alu_rdy), 32'd1);
        step();
        alu_vld = 1'b0;
        #1;
        chk_wr("t3.w3", 1'b1, 4'd8, 8'h44);
        step();
        chk_wr("t3.w4", 1'b1, 4'd9, 8'h66);
        step();
        chk("t3.idle", 32'(wr_en), 32'd0);
        chk("t3.err", 32'(err), 32'd0);

        // 4: scoreboard and FIFO full
        ld_issue = 1'b1; ld_issue_addr = 4'd1;
        step();
        #1;
        chk("t4.rdy_busy_r1", 32'(ld_issue_rdy), 32'd0);
        ld_issue_addr = 4'd5;
        #1;
        chk("t4.rdy_r5", 32'(ld_issue_rdy), 32'd1);
        step();
        ld_issue_addr = 4'd0; rd_addrA = 4'd1; rd_addrB = 4'd5;
        #1;
        chk("t4.rdy_full", 32'(ld_issue_rdy), 32'd0);
        chk("t4.stallA_r1", 32'(stallA), 32'd1);
        chk("t4.stallB_r5", 32'(stallB), 32'd1);
        ld_rsp_vld = 1'b1; ld_rsp_dat = 8'hAA;
        #1;
        chk("t4.rdy_full_pop", 32'(ld_issue_rdy), 32'd0);
        step();
        ld_issue = 1'b0; ld_rsp_dat = 8'hBB;
        #1;
        chk_wr("t4.r1", 1'b1, 4'd1, 8'hAA);
        chk("t4.stallA_clr", 32'(stallA), 32'd0);
        step();
        ld_rsp_vld = 1'b0;
        #1;
        chk_wr("t4.r5", 1'b1, 4'd5, 8'hBB);
        chk("t4.stallB_clr", 32'(stallB), 32'd0);
        ld_issue_addr = 4'd1;
        #1;
        chk("t4.rdy_free", 32'(ld_issue_rdy), 32'd1);
        step();

        // 5: protocol errors
        ld_rsp_vld = 1'b1; ld_rsp_dat = 8'hEE;
        step();
        ld_rsp_vld = 1'b0;
        #1;
        chk("t5.err_rsp", 32'(err), 32'd1);
        chk("t5.no_wr", 32'(wr_en), 32'd0);
        step();
        chk("t5.err_sticky", 32'(err), 32'd1);
        do_reset();
        chk("t5.err_clr", 32'(err), 32'd0);
        ld_issue = 1'b1; ld_issue_addr = 4'd1;
        step();
        ld_issue = 1'b0;
        alu_vld = 1'b1; alu_addr = 4'd1; alu_dat = 8'h77;
        #1;
        chk("t5.waw_rdy", 32'(alu_rdy), 32'd1);
        step();
        alu_vld = 1'b0;
        #1;
        chk("t5.err_waw", 32'(err), 32'd1);
        chk_wr("t5.waw_wr", 1'b1, 4'd1, 8'h77);
        chk("t5.busy_kept", 32'(stallA), 32'd1);

        // 6: reset with two loads outstanding
        ld_issue = 1'b1; ld_issue_addr = 4'd2; rd_addrB = 4'd2;
        step();
        ld_issue = 1'b0;
        #1;
        chk("t6.stallB_pre", 32'(stallB), 32'd1);
        chk("t6.full_pre", 32'(ld_issue_rdy), 32'd0);
        do_reset();
        chk("t6.stallA", 32'(stallA), 32'd0);
        chk("t6.stallB", 32'(stallB), 32'd0);
        chk("t6.alu_rdy", 32'(alu_rdy), 32'd1);
        chk("t6.issue_rdy", 32'(ld_issue_rdy), 32'd1);
        chk("t6.wr_en", 32'(wr_en), 32'd0);
        chk("t6.err_clr", 32'(err), 32'd0);
        ld_rsp_vld = 1'b1; ld_rsp_dat = 8'h99;
        step();
        ld_rsp_vld = 1'b0;
        #1;
        chk("t6.err_late", 32'(err), 32'd1);
        chk("t6.no_wr", 32'(wr_en), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
